alu_cmd_responder: RTL and testbench
====================================

# alu_cmd_responder

Sequential command-responder front end for the 8-bit ALU datapath. It accepts an operand/opcode command (op1, op2, one-hot select) over a valid/ready request channel and computes the result, including an iterative 8-cycle multiply. It returns the result over a valid/ready response channel. It is the hardware counterpart of the stimulus-driving side: the block that answers ALU commands rather than issuing them.

## Interface
- No parameters; all data paths are fixed at 8 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  block can accept a command
- op1  in  8  first operand
- op2  in  8  second operand
- select  in  8  one-hot opcode
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- res  out  8  result
- carry  out  1  carry, borrow or overflow flag
- err  out  1  illegal select flag

## Operation
- Opcodes are one-hot on select:
  - bit0 PASS: res=op1
  - bit1 ADD: res=(op1+op2)[7:0]; carry=sum bit 8
  - bit2 SUB: res=(op1-op2) mod 256; carry=1 if op1<op2 (borrow)
  - bit3 AND
  - bit4 OR
  - bit5 XOR
  - bit6 NOT: res=~op1
  - bit7 MUL: res=(op1*op2)[7:0]; carry=1 if product[15:8]!=0
- Logic, PASS and NOT ops force carry=0.
- An illegal select is 0x00 or more than one bit set. It gives err=1, res=0x00, carry=0, with single-cycle-op timing.
- FSM states:
  - IDLE
    - req_ready=1.
    - On req_valid, latch op1/op2/select and go to EXEC.
    - For MUL, also clear the 16-bit accumulator and load the 3-bit counter with 0.
  - EXEC
    - Non-MUL or illegal: compute and register res/carry/err, then go to RESP.
    - MUL: one shift-add step per cycle, using op2 bit[count] to add op1<<count. At count=7, register the result and go to RESP. Otherwise increment count.
  - RESP
    - rsp_valid=1.
    - Hold res/carry/err stable until rsp_ready=1, then go to IDLE.
- Only one command is in flight at a time. Commands are not queued.
- Inputs op1/op2/select are ignored outside the IDLE acceptance cycle. Changing them during EXEC/RESP has no effect.

## Timing
- Reset (rst=1 at an edge):
  - state goes to IDLE, counter and accumulator are cleared.
  - res=0x00, carry=0, err=0, rsp_valid=0.
  - req_ready=0 while rst is high.
- Reset mid-EXEC or mid-RESP aborts the command. No response is ever issued for it.
- req_ready = (state==IDLE) && !rst. It is a combinational decode of the state register.
- A request is accepted at edge k when req_valid && req_ready.
- Single-cycle ops and illegal select: EXEC runs in cycle k+1 and rsp_valid rises after edge k+1. Accept-to-rsp_valid latency is 2 cycles.
- MUL: EXEC runs for 8 cycles (k+1..k+8) and rsp_valid rises after edge k+8. Latency is 9 cycles.
- A response handshake at edge m (rsp_valid && rsp_ready) returns the block to IDLE. req_ready is 1 in cycle m+1, so the minimum command spacing is 3 cycles.
- If rsp_ready is already 1 when rsp_valid rises, RESP lasts exactly 1 cycle.
- res/carry/err keep their last values after the handshake, until the next result registers.
- rst takes priority over every handshake in the same cycle.

## Test plan
- op1=0xAB, op2=0xCC, select=0x02 (ADD) -> res=0x77, carry=1, err=0; rsp_valid 2 cycles after accept.
- Same operands, select=0x04 / 0x08 / 0x10 / 0x20 / 0x40 -> res=0xDF carry=1 / 0x88 / 0xEF / 0x67 / 0x54, with carry=0 for the logic ops.
- Same operands, select=0x80 (MUL) -> res=0x44, carry=1 (product 0x8844); rsp_valid exactly 9 cycles after accept; req_ready=0 throughout.
- select=0x00, then select=0x06 -> err=1, res=0x00, carry=0 for each; latency 2.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, and toggle op1/op2/select plus req_valid meanwhile -> outputs stable, no new accept; release gives one handshake, then req_ready=1 the next cycle.
- Assert rst for 1 cycle at MUL EXEC count=4 -> no rsp_valid, all outputs 0x00/0, req_ready=1 the cycle after rst drops; next ADD 0x01+0x01 gives res=0x02.

Source files
------------

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder
// Answers one 8-bit ALU command at a time over valid/ready channels.
// A command (op1, op2, one-hot select) is latched in IDLE. Single-cycle ops
// and illegal selects resolve in one EXEC cycle. MUL runs as 8 shift-add steps.
// The result is then held in RESP until the consumer takes it.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  command present            req_ready  block can accept a command
//   op1, op2   operands (8 bit)           select     one-hot opcode (8 bit)
//   rsp_valid  result present             rsp_ready  consumer accepts result
//   res        result (8 bit)             carry      carry / borrow / overflow
//   err        illegal select flag
module alu_cmd_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic [7:0] select,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] res,
  output logic       carry,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic [7:0]  op1_p0, op2_p0, sel_p0;
  logic [2:0]  cnt;
  logic [15:0] acc, acc_step;
  logic        is_mul;
  logic [9:0]  single_p0;

  // Returns {err, carry, res} for every opcode except MUL.
  // A zero or multi-hot select yields err=1 with res/carry cleared.
  function automatic logic [9:0] alu_single(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] s);
    logic [8:0] sum;
    logic [9:0] r;
    r   = 10'h200;
    sum = 9'd0;
    if ((s != 8'd0) && ((s & (s - 8'd1)) == 8'd0)) begin
      r = 10'd0;
      case (s)
        8'h01: r[7:0] = a;
        8'h02: begin
          sum    = {1'b0, a} + {1'b0, b};
          r[8:0] = sum;
        end
        8'h04: begin
          // Bit 8 of the 9-bit difference is the borrow (a < b).
          sum    = {1'b0, a} - {1'b0, b};
          r[8:0] = sum;
        end
        8'h08:   r[7:0] = a & b;
        8'h10:   r[7:0] = a | b;
        8'h20:   r[7:0] = a ^ b;
        8'h40:   r[7:0] = ~a;
        default: r = 10'd0;
      endcase
    end
    return r;
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  assign is_mul    = (sel_p0 == 8'h80);
  assign single_p0 = alu_single(op1_p0, op2_p0, sel_p0);
  // One shift-add step: add op1 << cnt when op2 bit[cnt] is set.
  assign acc_step  = acc + (op2_p0[cnt] ? ({8'h00, op1_p0} << cnt) : 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = EXEC;
      EXEC: if (!is_mul || (cnt == 3'd7)) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch (p0) and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 3'd0;
      acc   <= 16'd0;
      res   <= 8'd0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op1_p0 <= op1;
          op2_p0 <= op2;
          sel_p0 <= select;
          cnt    <= 3'd0;
          acc    <= 16'd0;
        end
        EXEC: if (is_mul) begin
          acc <= acc_step;
          if (cnt == 3'd7) begin
            res   <= acc_step[7:0];
            carry <= |acc_step[15:8];
            err   <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end else begin
          {err, carry, res} <= single_p0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Bench for alu_cmd_responder: table of commands with expected results and
// latency, a scoreboard queue of expected responses, plus hand-written
// backpressure and mid-multiply reset sequences.
module tb_alu_cmd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] op1, op2, select;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] res;
  logic       carry;
  logic       err;

  alu_cmd_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op1(op1), .op2(op2), .select(select),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .res(res), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, s, r;
    logic       c, e;
    int         lat;
  } vec_t;

  vec_t       tbl[16];
  logic [9:0] sb[$];   // expected {err, carry, res}
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one command, push its expectation, wait (bounded) for rsp_valid.
  // Returns at a negedge with rsp_valid seen; lat counts edges from accept.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                       input logic [9:0] exp, output int lat);
    int stray;
    @(negedge clk);
    check("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    op1 = a; op2 = b; select = s;
    sb.push_back(exp);
    @(posedge clk);
    lat   = 1;
    stray = 0;
    @(negedge clk);
    req_valid = 1'b0;
    op1 = 8'($urandom); op2 = 8'($urandom); select = 8'($urandom);
    while (!rsp_valid && lat < 20) begin
      if (req_ready) stray++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("req_ready_low_busy", stray, 0);
  endtask

  // Compare the held response with the scoreboard head, then handshake.
  task automatic respond(input string name);
    logic [9:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
    check({name, "_rsp_valid"}, int'(rsp_valid), 1);
    check({name, "_res"},   int'(res),   int'(exp[7:0]));
    check({name, "_carry"}, int'(carry), int'(exp[8]));
    check({name, "_err"},   int'(err),   int'(exp[9]));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_valid_drop"}, int'(rsp_valid), 0);
    check({name, "_req_ready_back"}, int'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    tbl[0]  = '{8'hAB, 8'hCC, 8'h02, 8'h77, 1'b1, 1'b0, 2};
    tbl[1]  = '{8'hAB, 8'hCC, 8'h04, 8'hDF, 1'b1, 1'b0, 2};
    tbl[2]  = '{8'hAB, 8'hCC, 8'h08, 8'h88, 1'b0, 1'b0, 2};
    tbl[3]  = '{8'hAB, 8'hCC, 8'h10, 8'hEF, 1'b0, 1'b0, 2};
    tbl[4]  = '{8'hAB, 8'hCC, 8'h20, 8'h67, 1'b0, 1'b0, 2};
    tbl[5]  = '{8'hAB, 8'hCC, 8'h40, 8'h54, 1'b0, 1'b0, 2};
    tbl[6]  = '{8'hAB, 8'hCC, 8'h80, 8'h44, 1'b1, 1'b0, 9};
    tbl[7]  = '{8'hAB, 8'hCC, 8'h00, 8'h00, 1'b0, 1'b1, 2};
    tbl[8]  = '{8'hAB, 8'hCC, 8'h06, 8'h00, 1'b0, 1'b1, 2};
    tbl[9]  = '{8'hAB, 8'hCC, 8'h01, 8'hAB, 1'b0, 1'b0, 2};
    tbl[10] = '{8'h10, 8'h20, 8'h02, 8'h30, 1'b0, 1'b0, 2};
    tbl[11] = '{8'h55, 8'h55, 8'h04, 8'h00, 1'b0, 1'b0, 2};
    tbl[12] = '{8'h0F, 8'h11, 8'h80, 8'hFF, 1'b0, 1'b0, 9};
    tbl[13] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 1'b1, 1'b0, 9};
    tbl[14] = '{8'h20, 8'h08, 8'h80, 8'h00, 1'b1, 1'b0, 9};
    tbl[15] = '{8'h05, 8'h07, 8'h08, 8'h05, 1'b0, 1'b0, 2};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    op1 = 8'h00; op2 = 8'h00; select = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res",       int'(res),       0);
    check("rst_carry",     int'(carry),     0);
    check("rst_err",       int'(err),       0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", int'(req_ready), 1);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].e, tbl[i].c, tbl[i].r}, lat);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      respond($sformatf("vec%0d", i));
    end

    // Backpressure: response held for 5 cycles while inputs churn.
    issue(8'h12, 8'h34, 8'h02, {1'b0, 1'b0, 8'h46}, lat);
    check("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      op1 = 8'($urandom); op2 = 8'($urandom); select = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_rsp_valid", int'(rsp_valid), 1);
      check("bp_hold_res",       int'(res),       8'h46);
      check("bp_hold_carry",     int'(carry),     0);
      check("bp_hold_err",       int'(err),       0);
      check("bp_hold_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    respond("bp");

    // Reset at MUL EXEC count=4: command is dropped, outputs cleared.
    @(negedge clk);
    req_valid = 1'b1; op1 = 8'hAB; op2 = 8'hCC; select = 8'h80;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", int'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_res",       int'(res),       0);
    check("abort_carry",     int'(carry),     0);
    check("abort_err",       int'(err),       0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("abort_req_ready", int'(req_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_response", seen, 0);
    issue(8'h01, 8'h01, 8'h02, {1'b0, 1'b0, 8'h02}, lat);
    check("after_abort_latency", lat, 2);
    respond("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
